l1a_readback_checker: RTL and testbench

//  Parametrised successor of the single-step L1A read-pointer block.

---
 rtl/l1a_readback_checker_if.sv | 28 ++
 rtl/l1a_readback_checker.sv | 134 +++++++++++++
 tb/tb_l1a_readback_checker.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l1a_readback_checker_if.sv
// Bus bundle between the L1A readback checker, the trigger/readout control and ram_L1A.
interface l1a_readback_checker_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ERR_W  = 16
);
  logic              start_check;
  logic              clr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_req;
  logic              busy;
  logic              check_valid;
  logic              check_err;
  logic [DATA_W-1:0] last_data;
  logic [ERR_W-1:0]  err_count;
  logic              overrun;

  modport master (
    output start_check, clr, rd_data,
    input  rd_addr, rd_req, busy, check_valid, check_err, last_data, err_count, overrun
  );

  modport slave (
    input  start_check, clr, rd_data,
    output rd_addr, rd_req, busy, check_valid, check_err, last_data, err_count, overrun
  );
endinterface

// File: rtl/l1a_readback_checker.sv
// Per rising edge of the async start_check strobe, reads one ram_L1A entry and
// compares it with a running expected-L1A counter; flags mismatches and overruns.
module l1a_readback_checker #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 16
) (
  input logic                   clk_i,
  input logic                   reset_i,
  l1a_readback_checker_if.slave bus
);
  localparam int unsigned       CNT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CMP  = 2'd3
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       wait_q;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic [DATA_W-1:0]      exp_q;
  logic [DATA_W-1:0]      last_data_q;
  logic [ERR_W-1:0]       err_count_q;
  logic                   rd_req_q;
  logic                   busy_q;
  logic                   check_valid_q;
  logic                   check_err_q;
  logic                   overrun_q;

  logic                   edge_c;
  logic                   mismatch_c;
  logic [ADDR_W-1:0]      rd_addr_d;
  logic [DATA_W-1:0]      exp_d;
  logic [ERR_W-1:0]       err_count_d;

  assign edge_c      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign mismatch_c  = (bus.rd_data != exp_q);
  assign rd_addr_d   = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
  assign exp_d       = exp_q + DATA_W'(1);
  assign err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + ERR_W'(1);

  // Synchroniser and edge flops ignore clr so a strobe in flight is not lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.start_check};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Read sequencer; rd_data is captured on the last WAIT clock so results show in CMP.
  always_ff @(posedge clk_i) begin
    if (reset_i || bus.clr) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      rd_addr_q     <= '0;
      exp_q         <= '0;
      last_data_q   <= '0;
      err_count_q   <= '0;
      rd_req_q      <= 1'b0;
      busy_q        <= 1'b0;
      check_valid_q <= 1'b0;
      check_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rd_req_q      <= 1'b0;
      check_valid_q <= 1'b0;
      check_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (edge_c) begin
            state_q  <= ST_REQ;
            rd_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (edge_c) overrun_q <= 1'b1;
          wait_q  <= WAIT_LOAD;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (edge_c) overrun_q <= 1'b1;
          if (wait_q == '0) begin
            last_data_q   <= bus.rd_data;
            check_valid_q <= 1'b1;
            check_err_q   <= mismatch_c;
            if (mismatch_c) err_count_q <= err_count_d;
            exp_q         <= exp_d;
            rd_addr_q     <= rd_addr_d;
            state_q       <= ST_CMP;
          end else begin
            wait_q <= wait_q - CNT_W'(1);
          end
        end
        ST_CMP: begin
          // Leaving CMP counts as IDLE, so an edge here starts the next read.
          if (edge_c) begin
            state_q  <= ST_REQ;
            rd_req_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.busy        = busy_q;
  assign bus.check_valid = check_valid_q;
  assign bus.check_err   = check_err_q;
  assign bus.last_data   = last_data_q;
  assign bus.err_count   = err_count_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_l1a_readback_checker.sv
// Randomised bench for l1a_readback_checker against an event-time reference model.
module tb_l1a_readback_checker;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LAT     = 2;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned ERR_W   = 2;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;
  localparam int          MAXC    = 8192;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l1a_readback_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) bus ();

  l1a_readback_checker #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W),
    .RD_LATENCY(LAT), .SYNC_STAGES(SYNC), .ERR_W(ERR_W)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_req = 0;
  bit chk_en = 1'b0;

  // Reference model: each read is an interval of posedges starting at its accept edge.
  bit samp [MAXC];
  int last_rst = -1;
  bit m_active = 1'b0;
  int m_acc    = 0;
  int m_exp    = 0;
  int m_addr   = 0;
  int m_err    = 0;
  int m_last   = 0;
  bit m_ovr    = 1'b0;
  bit m_req    = 1'b0;
  bit m_cv     = 1'b0;
  bit m_ce     = 1'b0;
  bit m_busy   = 1'b0;
  int fq[$];

  function automatic bit smp(input int p);
    if (p < 0 || p <= last_rst || p >= MAXC) return 1'b0;
    return samp[p];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic compare_all();
    if (!chk_en) return;
    check("rd_addr",     32'(bus.rd_addr),     32'(m_addr));
    check("rd_req",      32'(bus.rd_req),      32'(m_req));
    check("busy",        32'(bus.busy),        32'(m_busy));
    check("check_valid", 32'(bus.check_valid), 32'(m_cv));
    check("check_err",   32'(bus.check_err),   32'(m_ce));
    check("last_data",   32'(bus.last_data),   32'(m_last));
    check("err_count",   32'(bus.err_count),   32'(m_err));
    check("overrun",     32'(bus.overrun),     32'(m_ovr));
  endtask

  task automatic model_update(input bit rst, input bit c, input bit st, input int d);
    int p;
    bit edge_seen;
    p = cyc;
    if (p < MAXC) samp[p] = st;
    m_req = 1'b0;
    m_cv  = 1'b0;
    m_ce  = 1'b0;
    if (rst || c) begin
      if (rst) begin
        last_rst = p;
        chk_en   = 1'b1;
      end
      m_active = 1'b0;
      m_exp    = 0;
      m_addr   = 0;
      m_err    = 0;
      m_last   = 0;
      m_ovr    = 1'b0;
    end else begin
      edge_seen = smp(p - int'(SYNC)) && !smp(p - int'(SYNC) - 1);
      if (m_active && p == m_acc + int'(LAT) + 1) begin
        m_cv   = 1'b1;
        m_ce   = (d != m_exp);
        if (m_ce && m_err < ERR_MAX) m_err++;
        m_last = d;
        m_exp  = (m_exp + 1) % (1 << DATA_W);
        m_addr = (m_addr + 1) % int'(DEPTH);
      end
      if (m_active && p >= m_acc + int'(LAT) + 2) m_active = 1'b0;
      if (edge_seen) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_acc    = p;
          m_req    = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    m_busy = m_active;
  endtask

  // One clock: compare at negedge, drive inputs, advance model at posedge.
  task automatic step(input bit rst, input bit c, input bit st);
    int d;
    compare_all();
    if (bus.rd_req === 1'b1) n_req++;
    reset           = rst;
    bus.clr         = c;
    bus.start_check = st;
    if (m_active && !rst && !c && (cyc + 1) == m_acc + int'(LAT) + 1) begin
      if (fq.size() > 0) d = fq.pop_front();
      else d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : m_exp;
    end else begin
      d = int'($urandom_range(0, 255));
    end
    bus.rd_data = DATA_W'(d);
    @(posedge clk);
    cyc++;
    model_update(rst, c, st, d);
    @(negedge clk);
  endtask

  task automatic pulse(output int req_addr);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("pulse_req", 32'(bus.rd_req), 32'd1);
    req_addr = int'(bus.rd_addr);
    repeat (5) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int a;
    int nr0;
    int exp6[5] = '{1, 2, 3, 3, 3};
    bit st;
    bus.clr         = 1'b0;
    bus.start_check = 1'b0;
    bus.rd_data     = '0;
    @(negedge clk);

    // Single read after reset
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("t1_rst_addr", 32'(bus.rd_addr), 32'd0);
    check("t1_rst_busy", 32'(bus.busy), 32'd0);
    check("t1_rst_err",  32'(bus.err_count), 32'd0);
    fq.push_back(0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("t1_no_early_req", 32'(bus.rd_req), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("t1_req", 32'(bus.rd_req), 32'd1);
    check("t1_req_addr", 32'(bus.rd_addr), 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("t1_cv", 32'(bus.check_valid), 32'd1);
    check("t1_ce", 32'(bus.check_err), 32'd0);
    check("t1_next_addr", 32'(bus.rd_addr), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("t1_cv_done", 32'(bus.check_valid), 32'd0);
    check("t1_idle", 32'(bus.busy), 32'd0);

    // ram returns 0,1,5
    repeat (2) step(1'b1, 1'b0, 1'b0);
    fq = '{0, 1, 5};
    repeat (3) pulse(a);
    check("t2_err", 32'(bus.err_count), 32'd1);
    check("t2_last", 32'(bus.last_data), 32'd5);

    // Address wrap at DEPTH
    repeat (2) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      fq.push_back(i);
      pulse(a);
      check("t3_addr", 32'(a), 32'(i % int'(DEPTH)));
    end
    check("t3_err", 32'(bus.err_count), 32'd0);

    // Overrun and clr
    repeat (2) step(1'b1, 1'b0, 1'b0);
    fq.push_back(0);
    nr0 = n_req;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    check("t4_one_req", 32'(n_req - nr0), 32'd1);
    check("t4_ovr", 32'(bus.overrun), 32'd1);
    check("t4_addr", 32'(bus.rd_addr), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("t4_clr_ovr", 32'(bus.overrun), 32'd0);
    check("t4_clr_addr", 32'(bus.rd_addr), 32'd0);
    fq.push_back(0);
    pulse(a);
    check("t4_clr_exp", 32'(bus.err_count), 32'd0);

    // Reset while waiting on ram
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_cv", 32'(bus.check_valid), 32'd0);
    check("t5_addr", 32'(bus.rd_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("t5_no_cv", 32'(bus.check_valid), 32'd0);
    end

    // Error counter saturation
    repeat (2) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      fq.push_back(8'hA0 + i);
      pulse(a);
      check("t6_err", 32'(bus.err_count), 32'(exp6[i]));
    end

    // Random traffic
    st = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 2) == 0) st = ~st;
      step(($urandom_range(0, 699) == 0), ($urandom_range(0, 149) == 0), st);
    end
    step(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
